alu_ctrl_sequencer: RTL
=======================

ALU_CTRL_SEQUENCER -- requirements
Module: alu_ctrl_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 alu_op  input  3  operation code, latched with start.
REQ-006 A  input  32  operand A, latched with start.
REQ-007 B  input  32  operand B, latched with start.
REQ-008 result_in  input  32  selected result returned from the 8x1 32-bit result mux.
REQ-009 s  output  3  select driven to the result mux.
REQ-010 mod_result  output  32  unsigned remainder A mod B, driven to the mux mod input.
REQ-011 result  output  32  registered operation result.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse; result valid.

Function
REQ-014 Op encoding SHALL be: and=000, or=001, xor=010, nor=011, less_than=100, add=101, sub=110, mod=111.
REQ-015 FSM states SHALL be IDLE, EXEC, MOD_LOOP, DONE.
REQ-016 In IDLE with start=1, the block SHALL latch alu_op, A and B. It SHALL go to MOD_LOOP if alu_op=111, else to EXEC.
REQ-017 In IDLE, start=0 SHALL keep the block in IDLE.
REQ-018 start SHALL be ignored in EXEC, MOD_LOOP and DONE; latched operands SHALL not change.
REQ-019 s SHALL equal the latched op from the cycle after start acceptance until the next acceptance. It SHALL be 000 after reset.
REQ-020 EXEC (one cycle): the block SHALL register result_in into result, then go to DONE.
REQ-021 MOD_LOOP SHALL run exactly 32 cycles of restoring remainder, MSB of A first. Each cycle: rem = {rem[30:0], A_bit}; if rem >= B (unsigned), rem = rem - B.
REQ-022 rem SHALL be cleared to 0 on acceptance.
REQ-023 After iteration 32, mod_result SHALL hold rem and the FSM SHALL go to EXEC.
REQ-024 B=0 SHALL give mod_result = A. No trap and no stall.
REQ-025 DONE (one cycle): done=1, then go to IDLE. A new start is accepted only from the following cycle.
REQ-026 Latency, with start sampled at edge 0: non-mod ops give done in cycle 2; mod gives done in cycle 34.
REQ-027 result and mod_result SHALL hold their values until the next EXEC or MOD_LOOP writes them.
REQ-028 The 6-bit iteration counter SHALL not wrap; the exit test is count==31 at iteration end.

Reset
REQ-029 Reset assertion at any time, including mid-MOD_LOOP, SHALL force IDLE immediately. It SHALL set s=000, result=0, mod_result=0, busy=0, done=0, rem=0 and count=0.
REQ-030 The first rising edge after reset release SHALL be able to accept start.

Structure
REQ-031 Package alu_pkg SHALL hold the op-code constants (REQ-014) and the FSM state encoding.
REQ-032 The remainder datapath (rem, count, compare/subtract) SHALL be one sub-module, mod_restoring_32bit, with inputs init/step and outputs rem and last. The FSM, operand latches and result register SHALL stay in alu_ctrl_sequencer.

Verification
REQ-033 The bench SHALL feed result_in from the team's 8x1 32-bit result mux, with the operation units connected to it.
REQ-034 add: A=5, B=7, op=101 -> s=101 from cycle 1, done in cycle 2, result=12.
REQ-035 mod: A=100, B=7, op=111 -> busy high cycles 1-34, done in cycle 34, result=mod_result=2.
REQ-036 mod by zero: A=0xDEADBEEF, B=0 -> result=0xDEADBEEF at cycle 34.
REQ-037 mod edge: A=0xFFFFFFFF, B=0xFFFFFFFF -> result=0; then A=3, B=0xFFFFFFFF -> result=3.
REQ-038 Busy case: start with op=110 (sub) pulsed on every cycle during a mod op -> no effect, and the mod result is correct. Reset asserted at cycle 10 of a mod -> all outputs 0 in the same cycle. Then sub A=1, B=2 -> result=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op-code and FSM state encodings shared by the ALU control sequencer
package alu_pkg;
  localparam int W = 32;
  localparam int ITER = 32;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_LT  = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_MOD = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MOD_LOOP = 2'd2,
    DONE     = 2'd3
  } state_e;
endpackage

// File: rtl/mod_restoring_32bit.sv
// mod_restoring_32bit: restoring remainder datapath, one dividend bit per step, MSB first
module mod_restoring_32bit
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         step,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] rem,
  output logic         last
);
  logic [5:0]   count;
  logic [4:0]   idx;
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic [W-1:0] rem_next;
  // shift in the next dividend bit and conditionally subtract; the shifted value
  // keeps its carry bit so divisors above 2^31 still compare correctly, and the
  // borrow out of the 33-bit difference means shifted < b
  always_comb begin
    idx      = 5'(ITER - 1) - count[4:0];
    shifted  = {rem, a[idx]};
    diff     = shifted - {1'b0, b};
    rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    last     = count == 6'(ITER - 1);
  end
  // remainder and iteration count; the FSM leaves after the 32nd step so count never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      count <= '0;
    end else if (init) begin
      rem   <= '0;
      count <= '0;
    end else if (step) begin
      rem   <= rem_next;
      count <= count + 6'd1;
    end
  end
endmodule

// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: sequences one ALU operation through an external result mux, with a multi-cycle mod
module alu_ctrl_sequencer
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   alu_op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] result_in,
  output logic [2:0]   s,
  output logic [W-1:0] mod_result,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         done
);
  state_e       state;
  state_e       state_next;
  logic [W-1:0] a_latched;
  logic [W-1:0] b_latched;
  logic         accept;
  logic         last;
  assign accept = (state == IDLE) && start;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // next-state: mod detours through the remainder loop before the common EXEC/DONE tail
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = start ? ((alu_op == OP_MOD) ? MOD_LOOP : EXEC) : IDLE;
      EXEC:     state_next = DONE;
      MOD_LOOP: state_next = last ? EXEC : MOD_LOOP;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // operand/select latches load only on acceptance; result captures the mux during EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s         <= '0;
      a_latched <= '0;
      b_latched <= '0;
      result    <= '0;
    end else begin
      if (accept) begin
        s         <= alu_op;
        a_latched <= A;
        b_latched <= B;
      end
      if (state == EXEC) result <= result_in;
    end
  end
  // remainder is cleared only when a mod is accepted so mod_result holds across other ops
  mod_restoring_32bit u_mod (
    .clk   (clk),
    .reset (reset),
    .init  (accept && (alu_op == OP_MOD)),
    .step  (state == MOD_LOOP),
    .a     (a_latched),
    .b     (b_latched),
    .rem   (mod_result),
    .last  (last)
  );
endmodule
